camera_pixel_packer: RTL and testbench

Producer side of the 9-bit RGB333 pixel bus consumed by the per-pixel colour-cost logic. It takes the camera's RGB565 byte stream, already synchronised into the system clock domain, and pairs bytes into pixels. It reduces each pixel to 3:3:3 as {R[2:0],G[2:0],B[2:0]} in bits [8:6],[5:3],[2:0] and writes it, with a linear address, into the frame BRAM. It also reports frame completion and malformed-line errors to the tracker.

---
 rtl/pixel_pkg.sv | 25 ++
 rtl/rgb565_to_rgb333.sv | 40 ++++
 rtl/camera_pixel_packer.sv | 152 +++++++++++++++
 tb/tb_camera_pixel_packer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the 9-bit RGB333 pixel bus.
// Producer (camera_pixel_packer) and consumer (colour-cost logic) both
// import the field positions from here so the bus layout lives in one place.
//   PIXEL_W            : width of a packed pixel
//   R_/G_/B_ MSB/LSB   : channel field positions {R[8:6],G[5:3],B[2:0]}
//   H_PIXELS_DEF/V_LINES_DEF : default active frame geometry
//   packer_state_t     : capture FSM states
package pixel_pkg;
  localparam int PIXEL_W = 9;
  localparam int R_MSB = 8;
  localparam int R_LSB = 6;
  localparam int G_MSB = 5;
  localparam int G_LSB = 3;
  localparam int B_MSB = 2;
  localparam int B_LSB = 0;

  localparam int H_PIXELS_DEF = 320;
  localparam int V_LINES_DEF  = 240;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2
  } packer_state_t;
endpackage

// File: rtl/rgb565_to_rgb333.sv
// Combinational RGB565 -> RGB333 reduction.
// Ports:
//   rgb565 in  16  {hi byte, lo byte} as delivered by the camera
//   rgb333 out  9  {R3,G3,B3}
// Build option: PACKER_ROUND_EN selects round-to-nearest with saturation;
// without it each channel is truncated to its top three bits.
module rgb565_to_rgb333
  import pixel_pkg::*;
(
  input  logic [15:0]        rgb565,
  output logic [PIXEL_W-1:0] rgb333
);

`ifdef PACKER_ROUND_EN
  logic [5:0] r_sum;
  logic [6:0] g_sum;
  logic [5:0] b_sum;

  // Adding half an output LSB before the shift rounds to nearest; the carry
  // into the top bit means the result would be 8, so clamp to 7.
  always_comb begin
    r_sum = {1'b0, rgb565[15:11]} + 6'd2;
    g_sum = {1'b0, rgb565[10:5]}  + 7'd4;
    b_sum = {1'b0, rgb565[4:0]}   + 6'd2;
    rgb333 = '0;
    rgb333[R_MSB:R_LSB] = r_sum[5] ? 3'd7 : r_sum[4:2];
    rgb333[G_MSB:G_LSB] = g_sum[6] ? 3'd7 : g_sum[5:3];
    rgb333[B_MSB:B_LSB] = b_sum[5] ? 3'd7 : b_sum[4:2];
  end
`else
  logic unused_lsbs;

  assign rgb333[R_MSB:R_LSB] = rgb565[15:13];
  assign rgb333[G_MSB:G_LSB] = rgb565[10:8];
  assign rgb333[B_MSB:B_LSB] = rgb565[4:2];
  // Truncation discards the channel LSBs.
  assign unused_lsbs = ^{rgb565[12:11], rgb565[7:5], rgb565[1:0]};
`endif

endmodule

// File: rtl/camera_pixel_packer.sv
// Camera byte stream -> RGB333 frame-buffer writer.
// Pairs RGB565 bytes into pixels, reduces them to RGB333 and writes them
// with a linear address into the frame BRAM. Reports frame completion and
// malformed lines.
// Ports:
//   clk, reset_n    system clock, async active-low reset
//   cam_vsync       synchronised VSYNC (high = vertical blank)
//   cam_href        synchronised HREF (high = active line)
//   cam_byte_valid  one-cycle strobe qualifying cam_data
//   cam_data        camera byte
//   pixel_data      packed RGB333 pixel
//   pixel_addr      BRAM write address
//   pixel_we        BRAM write enable, one cycle per pixel
//   frame_done      one-cycle pulse at end of an active frame
//   line_err        sticky per frame: odd byte count or overlong line
// Build option: PACKER_ROUND_EN (rounding in rgb565_to_rgb333).
module camera_pixel_packer
  import pixel_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = 17
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic               cam_byte_valid,
  input  logic [7:0]         cam_data,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic               pixel_we,
  output logic               frame_done,
  output logic               line_err
);

  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [CW-1:0]     COL_MAX   = CW'(H_PIXELS);
  localparam logic [LW-1:0]     LINE_MAX  = LW'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  packer_state_t state, state_nxt;
  logic          vsync_q, href_q;
  logic          phase;
  logic [7:0]    hi;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [ADDR_W-1:0] line_base;
  logic          frame_done_nxt;
  logic [PIXEL_W-1:0] rgb333;

  logic vsync_rise, vsync_fall;
  logic byte_ok, pix_done, in_frame, eol, phase_after;

  assign vsync_rise = cam_vsync & ~vsync_q;
  assign vsync_fall = ~cam_vsync & vsync_q;

  assign byte_ok  = (state == ACTIVE) && cam_byte_valid && cam_href;
  assign pix_done = byte_ok && phase;
  assign in_frame = (col < COL_MAX) && (line < LINE_MAX);
  // VSYNC rising inside a line closes that line just like an HREF fall.
  assign eol      = (state == ACTIVE) && href_q && (!cam_href || vsync_rise);
  // Phase as it stands after this cycle's byte; a 1 at end of line means a
  // dangling half pixel.
  assign phase_after = byte_ok ? ~phase : phase;

  rgb565_to_rgb333 u_conv (
    .rgb565 ({hi, cam_data}),
    .rgb333 (rgb333)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE:   if (vsync_rise) state_nxt = VBLANK;
      VBLANK: if (vsync_fall) state_nxt = ACTIVE;
      ACTIVE: if (vsync_rise) begin
        state_nxt      = VBLANK;
        frame_done_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      phase      <= 1'b0;
      hi         <= '0;
      col        <= '0;
      line       <= '0;
      line_base  <= '0;
      pixel_data <= '0;
      pixel_addr <= '0;
      pixel_we   <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      pixel_we   <= 1'b0;
      frame_done <= frame_done_nxt;

      if (state == VBLANK && vsync_fall) begin
        col       <= '0;
        line      <= '0;
        line_base <= '0;
        line_err  <= 1'b0;
        phase     <= 1'b0;
      end

      if (byte_ok && !phase) begin
        hi    <= cam_data;
        phase <= 1'b1;
      end

      if (pix_done) begin
        phase <= 1'b0;
        if (in_frame) begin
          pixel_we   <= 1'b1;
          pixel_addr <= line_base + ADDR_W'(col);
          pixel_data <= rgb333;
          col        <= col + CW'(1);
        end else if (line < LINE_MAX) begin
          // Overlong line; rows past the frame drop silently instead.
          line_err <= 1'b1;
        end
      end

      // Placed after the pixel write so a pixel completing on the last
      // cycle of the line still lands at the old column.
      if (eol) begin
        if (phase_after) line_err <= 1'b1;
        phase <= 1'b0;
        col   <= '0;
        if (line < LINE_MAX) begin
          line      <= line + LW'(1);
          line_base <= line_base + LINE_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_pixel_packer.sv
module tb_camera_pixel_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cam_vsync, cam_href, cam_byte_valid;
  logic [7:0]  cam_data;
  logic [8:0]  pixel_data;
  logic [16:0] pixel_addr;
  logic        pixel_we, frame_done, line_err;

  always #5 clk = ~clk;

  camera_pixel_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_href),
    .cam_byte_valid (cam_byte_valid),
    .cam_data       (cam_data),
    .pixel_data     (pixel_data),
    .pixel_addr     (pixel_addr),
    .pixel_we       (pixel_we),
    .frame_done     (frame_done),
    .line_err       (line_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int addr; int data; int cyc; } exp_t;
  exp_t sb[$];

  typedef struct { logic [7:0] hi; logic [7:0] lo; logic [8:0] exp; } vec_t;
  vec_t tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected RGB333 for a byte pair, straight from the channel formulas.
  function automatic int model(input logic [7:0] h, input logic [7:0] l);
    int r5, g6, b5, r3, g3, b3;
    r5 = int'(h[7:3]);
    g6 = int'({h[2:0], l[7:5]});
    b5 = int'(l[4:0]);
`ifdef PACKER_ROUND_EN
    r3 = (r5 + 2) / 4; if (r3 > 7) r3 = 7;
    g3 = (g6 + 4) / 8; if (g3 > 7) g3 = 7;
    b3 = (b5 + 2) / 4; if (b3 > 7) b3 = 7;
`else
    r3 = r5 / 4;
    g3 = g6 / 8;
    b3 = b5 / 4;
`endif
    return r3 * 64 + g3 * 8 + b3;
  endfunction

  // Scoreboard: every write must match the oldest expectation, including
  // the cycle it was due on.
  always @(negedge clk) begin
    exp_t e;
    if (pixel_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0h", pixel_addr, pixel_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", int'(pixel_addr), e.addr);
        chk("wr_data", int'(pixel_data), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_data       = b;
    cam_byte_valid = 1'b1;
    tick();
    cam_byte_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] h, input logic [7:0] l,
                          input bit exp, input int addr, input int data);
    send_byte(h);
    if (exp) sb.push_back('{addr, data, cyc + 1});
    send_byte(l);
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    tbl[0] = '{8'hF8, 8'h00, 9'h1C0};
    tbl[1] = '{8'h07, 8'hE0, 9'h038};
    tbl[2] = '{8'h00, 8'h1F, 9'h007};
`ifdef PACKER_ROUND_EN
    tbl[3] = '{8'h30, 8'h00, 9'h080};
`else
    tbl[3] = '{8'h30, 8'h00, 9'h040};
`endif
    tbl[4] = '{8'hFF, 8'hFF, 9'h1FF};
    tbl[5] = '{8'h84, 8'h10, 9'h124};

    reset_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_byte_valid = 1'b0; cam_data = 8'h00;
    repeat (3) tick();
    chk("rst_we", int'(pixel_we), 0);
    chk("rst_addr", int'(pixel_addr), 0);
    chk("rst_data", int'(pixel_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_line_err", int'(line_err), 0);
    reset_n = 1'b1;
    tick();

    // Data before any VSYNC: ignored.
    cam_href = 1'b1; tick();
    send_pix(8'hF8, 8'h00, 0, 0, 0);
    send_pix(8'h07, 8'hE0, 0, 0, 0);
    cam_href = 1'b0; repeat (2) tick();

    vsync_pulse();
    chk("idle_no_frame_done", int'(frame_done), 0);

    // Line 0: decode table.
    cam_href = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin
      send_pix(tbl[i].hi, tbl[i].lo, 1, i, int'(tbl[i].exp));
      tick();
    end
    cam_href = 1'b0; repeat (2) tick();
    chk("line0_err", int'(line_err), 0);

    // Line 1: one pixel plus a dangling byte.
    cam_href = 1'b1; tick();
    send_pix(8'hF8, 8'h00, 1, 320, 'h1C0);
    send_byte(8'h12);
    cam_href = 1'b0; repeat (2) tick();
    chk("odd_line_err", int'(line_err), 1);

    // Line 2 starts at 640 regardless of the short line.
    cam_href = 1'b1; tick();
    send_pix(8'h07, 8'hE0, 1, 640, 'h038);
    cam_href = 1'b0; tick();

    cam_vsync = 1'b1; tick();
    chk("frame_done_pulse", int'(frame_done), 1);
    tick();
    chk("frame_done_1cyc", int'(frame_done), 0);
    chk("err_sticky_vblank", int'(line_err), 1);
    cam_vsync = 1'b0; repeat (2) tick();
    chk("err_clear_new_frame", int'(line_err), 0);

    // Overlong line: 321 pixels back to back.
    cam_href = 1'b1; tick();
    for (int i = 0; i < 321; i++) begin
      logic [7:0] h, l;
      h = 8'(i);
      l = 8'(i * 7 + 3);
      send_pix(h, l, i < 320, i, model(h, l));
    end
    cam_href = 1'b0; repeat (2) tick();
    chk("overlong_err", int'(line_err), 1);
    cam_href = 1'b1; tick();
    send_pix(8'h00, 8'h1F, 1, 320, 'h007);
    cam_href = 1'b0; repeat (2) tick();

    // VSYNC rising mid-line with a dangling byte.
    cam_href = 1'b1; tick();
    send_pix(8'h84, 8'h10, 1, 640, 'h124);
    send_byte(8'h55);
    cam_vsync = 1'b1; tick();
    chk("midline_frame_done", int'(frame_done), 1);
    cam_href = 1'b0; tick();
    chk("midline_frame_done_1cyc", int'(frame_done), 0);
    cam_vsync = 1'b0; repeat (2) tick();

    // Reset mid-line.
    cam_href = 1'b1; tick();
    send_pix(8'hF8, 8'h00, 1, 0, 'h1C0);
    send_pix(8'h00, 8'h1F, 1, 1, 'h007);
    #5;
    reset_n = 1'b0;
    #1;
    chk("async_rst_we", int'(pixel_we), 0);
    chk("async_rst_addr", int'(pixel_addr), 0);
    chk("async_rst_data", int'(pixel_data), 0);
    tick();
    reset_n = 1'b1;
    tick();
    send_pix(8'hF8, 8'h00, 0, 0, 0);
    send_pix(8'h30, 8'h00, 0, 0, 0);
    cam_href = 1'b0; tick();
    cam_vsync = 1'b1; tick();
    chk("post_rst_no_frame_done", int'(frame_done), 0);
    tick();
    cam_vsync = 1'b0; repeat (2) tick();
    cam_href = 1'b1; tick();
    send_pix(8'h07, 8'hE0, 1, 0, 'h038);
    cam_href = 1'b0; repeat (3) tick();

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
